// File: rtl/radiation_playback_engine_if.sv
// Playback delivery bundle: PS register/ack path and histogram valid/ready path.
// The engine drives values and strobes; the consumer returns the acknowledges.
interface radiation_playback_engine_if #(
   parameter int VALUE_WIDTH = 16
);
   logic [VALUE_WIDTH-1:0] ps_value;
   logic                   ps_value_ready;
   logic                   ps_value_read;
   logic [VALUE_WIDTH-1:0] hist_value;
   logic                   hist_valid;
   logic                   hist_ready;

   modport master (
      output ps_value,
      output ps_value_ready,
      input  ps_value_read,
      output hist_value,
      output hist_valid,
      input  hist_ready
   );

   modport slave (
      input  ps_value,
      input  ps_value_ready,
      output ps_value_read,
      input  hist_value,
      input  hist_valid,
      output hist_ready
   );
endinterface

// File: rtl/radiation_playback_engine.sv
// Circular buffer of {delay,value} entries written by the PS, replayed with
// cycle-accurate spacing to either the PS or the hardware histogram.
module radiation_playback_engine #(
   parameter int ADDR_WIDTH  = 14,
   parameter int VALUE_WIDTH = 16,
   parameter int DELAY_WIDTH = 16,
   parameter int STALL_DELAY = 50000,
   parameter int IRQ_HOLDOFF = 50
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [DELAY_WIDTH+VALUE_WIDTH-1:0] ethernet_value,
   input  logic                               ethernet_write,
   input  logic [ADDR_WIDTH:0]                load_floor,
   input  logic                               clear_request,
   input  logic                               use_hardware,
   radiation_playback_engine_if.master        play_if,
   output logic                               request_values,
   output logic [ADDR_WIDTH:0]                occupancy,
   output logic [31:0]                        values_received,
   output logic [31:0]                        values_sent,
   output logic                               overflow,
   output logic [15:0]                        underflow_stalls,
   output logic [DELAY_WIDTH-1:0]             max_delay
);

   localparam int DEPTH   = 1 << ADDR_WIDTH;
   localparam int EW      = DELAY_WIDTH + VALUE_WIDTH;
   localparam int STALL_W = $clog2(STALL_DELAY + 1);
   localparam int HOLD_W  = $clog2(IRQ_HOLDOFF + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_WAIT,
      S_PRESENT,
      S_STALL
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
   logic                   write_prev_q;
   logic                   wr_req_q;
   logic [EW-1:0]          wr_data_q;
   logic                   read_prev_q;
   logic                   mode_q, mode_d;
   logic [VALUE_WIDTH-1:0] ps_value_q, ps_value_d;
   logic [VALUE_WIDTH-1:0] hist_value_q, hist_value_d;
   logic [DELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
   logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic [31:0]            values_received_q, values_received_d;
   logic [31:0]            values_sent_q, values_sent_d;
   logic                   overflow_q, overflow_d;
   logic [15:0]            underflow_q, underflow_d;
   logic [DELAY_WIDTH-1:0] max_delay_q, max_delay_d;
   logic                   request_q, request_d;
   logic [HOLD_W-1:0]      holdoff_q, holdoff_d;

   logic [EW-1:0]          mem [DEPTH];
   logic [EW-1:0]          mem_rdata;

   logic                   full;
   logic                   pop;
   logic                   wr_accept;
   logic                   rd_en;
   logic [DELAY_WIDTH-1:0] entry_delay;
   logic [VALUE_WIDTH-1:0] entry_value;

   assign occupancy   = wr_ptr_q - rd_ptr_q;
   assign full        = (occupancy == (ADDR_WIDTH+1)'(DEPTH));
   assign pop         = (state_q == S_PRESENT) &&
                        (mode_q ? play_if.hist_ready : (play_if.ps_value_read & ~read_prev_q));
   assign wr_accept   = wr_req_q && (!full || pop);
   assign rd_en       = (state_q == S_FETCH) && (occupancy != '0);
   assign entry_delay = mem_rdata[EW-1:VALUE_WIDTH];
   assign entry_value = mem_rdata[VALUE_WIDTH-1:0];

   // Buffer storage carries no reset; contents after reset are undefined.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_q;
      end
      if (rd_en) begin
         mem_rdata <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
   end

   always_comb begin
      state_d           = state_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      mode_d            = mode_q;
      ps_value_d        = ps_value_q;
      hist_value_d      = hist_value_q;
      delay_cnt_d       = delay_cnt_q;
      stall_cnt_d       = stall_cnt_q;
      values_received_d = values_received_q;
      values_sent_d     = values_sent_q;
      overflow_d        = overflow_q;
      underflow_d       = underflow_q;
      max_delay_d       = max_delay_q;

      if (wr_req_q) begin
         if (wr_accept) begin
            wr_ptr_d          = wr_ptr_q + (ADDR_WIDTH+1)'(1);
            values_received_d = values_received_q + 32'd1;
         end else begin
            overflow_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (occupancy == '0) begin
               state_d     = S_STALL;
               stall_cnt_d = STALL_W'(STALL_DELAY - 1);
               if (underflow_q != 16'hFFFF) begin
                  underflow_d = underflow_q + 16'd1;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            delay_cnt_d = entry_delay;
            mode_d      = use_hardware;
            if (entry_delay > max_delay_q) begin
               max_delay_d = entry_delay;
            end
            if (use_hardware) begin
               hist_value_d = entry_value;
            end else begin
               ps_value_d = entry_value;
            end
            state_d = (entry_delay == '0) ? S_PRESENT : S_WAIT;
         end
         S_WAIT: begin
            // Leaving on the count of one yields exactly N cycles in WAIT.
            if (delay_cnt_q <= DELAY_WIDTH'(1)) begin
               delay_cnt_d = '0;
               state_d     = S_PRESENT;
            end else begin
               delay_cnt_d = delay_cnt_q - DELAY_WIDTH'(1);
            end
         end
         S_PRESENT: begin
            if (pop) begin
               rd_ptr_d      = rd_ptr_q + (ADDR_WIDTH+1)'(1);
               values_sent_d = values_sent_q + 32'd1;
               state_d       = S_FETCH;
            end
         end
         S_STALL: begin
            if (stall_cnt_q == '0) begin
               state_d = S_FETCH;
            end else begin
               stall_cnt_d = stall_cnt_q - STALL_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Clear wins over set, and a running holdoff keeps the interrupt low.
   always_comb begin
      request_d = request_q;
      holdoff_d = holdoff_q;
      if (clear_request) begin
         request_d = 1'b0;
         holdoff_d = HOLD_W'(IRQ_HOLDOFF);
      end else if (holdoff_q != '0) begin
         request_d = 1'b0;
         holdoff_d = holdoff_q - HOLD_W'(1);
      end else if (start || ((state_q != S_IDLE) && (occupancy <= load_floor))) begin
         request_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= S_IDLE;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         write_prev_q      <= 1'b0;
         wr_req_q          <= 1'b0;
         wr_data_q         <= '0;
         read_prev_q       <= 1'b0;
         mode_q            <= 1'b0;
         ps_value_q        <= '0;
         hist_value_q      <= '0;
         delay_cnt_q       <= '0;
         stall_cnt_q       <= '0;
         values_received_q <= '0;
         values_sent_q     <= '0;
         overflow_q        <= 1'b0;
         underflow_q       <= '0;
         max_delay_q       <= '0;
         request_q         <= 1'b0;
         holdoff_q         <= '0;
      end else begin
         state_q           <= state_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         write_prev_q      <= ethernet_write;
         wr_req_q          <= ethernet_write & ~write_prev_q;
         wr_data_q         <= ethernet_value;
         read_prev_q       <= play_if.ps_value_read;
         mode_q            <= mode_d;
         ps_value_q        <= ps_value_d;
         hist_value_q      <= hist_value_d;
         delay_cnt_q       <= delay_cnt_d;
         stall_cnt_q       <= stall_cnt_d;
         values_received_q <= values_received_d;
         values_sent_q     <= values_sent_d;
         overflow_q        <= overflow_d;
         underflow_q       <= underflow_d;
         max_delay_q       <= max_delay_d;
         request_q         <= request_d;
         holdoff_q         <= holdoff_d;
      end
   end

   assign play_if.ps_value       = ps_value_q;
   assign play_if.ps_value_ready = (state_q == S_PRESENT) && !mode_q;
   assign play_if.hist_value     = hist_value_q;
   assign play_if.hist_valid     = (state_q == S_PRESENT) && mode_q;

   assign request_values   = request_q;
   assign values_received  = values_received_q;
   assign values_sent      = values_sent_q;
   assign overflow         = overflow_q;
   assign underflow_stalls = underflow_q;
   assign max_delay        = max_delay_q;

endmodule

// File: tb/tb_radiation_playback_engine.sv
// Directed bench for radiation_playback_engine with a small buffer (8 entries)
// and short stall delay so that every boundary is reachable quickly.
module tb_radiation_playback_engine;

   localparam int AW = 3;
   localparam int VW = 16;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [DW+VW-1:0] ethernet_value = '0;
   logic            ethernet_write = 1'b0;
   logic [AW:0]     load_floor = '0;
   logic            clear_request = 1'b0;
   logic            use_hardware = 1'b1;
   logic            request_values;
   logic [AW:0]     occupancy;
   logic [31:0]     values_received;
   logic [31:0]     values_sent;
   logic            overflow;
   logic [15:0]     underflow_stalls;
   logic [DW-1:0]   max_delay;

   int checks = 0;
   int errors = 0;

   radiation_playback_engine_if #(.VALUE_WIDTH(VW)) play_if ();

   radiation_playback_engine #(
      .ADDR_WIDTH (AW),
      .VALUE_WIDTH(VW),
      .DELAY_WIDTH(DW),
      .STALL_DELAY(10),
      .IRQ_HOLDOFF(50)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .ethernet_value  (ethernet_value),
      .ethernet_write  (ethernet_write),
      .load_floor      (load_floor),
      .clear_request   (clear_request),
      .use_hardware    (use_hardware),
      .play_if         (play_if.master),
      .request_values  (request_values),
      .occupancy       (occupancy),
      .values_received (values_received),
      .values_sent     (values_sent),
      .overflow        (overflow),
      .underflow_stalls(underflow_stalls),
      .max_delay       (max_delay)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic write_entry(input logic [DW-1:0] delay, input logic [VW-1:0] value);
      ethernet_value = {delay, value};
      ethernet_write = 1'b1;
      tick();
      ethernet_write = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      int tm[4];
      logic [VW-1:0] vv[4];

      play_if.ps_value_read = 1'b0;
      play_if.hist_ready    = 1'b1;
      tick();
      tick();
      check_output("reset_hist_valid", 64'(play_if.hist_valid), 64'd0);
      check_output("reset_ps_ready", 64'(play_if.ps_value_ready), 64'd0);
      check_output("reset_request", 64'(request_values), 64'd0);
      reset = 1'b1;
      tick();

      // Hardware path, three entries, spacing of delay+2 per sample.
      write_entry(16'd4, 16'h0011);
      write_entry(16'd0, 16'h0022);
      write_entry(16'd2, 16'h0033);
      check_output("hw_occupancy", 64'(occupancy), 64'd3);
      check_output("hw_received", 64'(values_received), 64'd3);
      pulse_start();
      check_output("start_sets_request", 64'(request_values), 64'd1);
      n = 0;
      for (int c = 0; c < 30; c++) begin
         if (play_if.hist_valid) begin
            if (n < 4) begin
               tm[n] = c;
               vv[n] = play_if.hist_value;
            end
            n++;
         end
         tick();
      end
      check_output("hw_valid_count", 64'(n), 64'd3);
      check_output("hw_t0", 64'(tm[0]), 64'd6);
      check_output("hw_v0", 64'(vv[0]), 64'h11);
      check_output("hw_t1", 64'(tm[1]), 64'd9);
      check_output("hw_v1", 64'(vv[1]), 64'h22);
      check_output("hw_t2", 64'(tm[2]), 64'd14);
      check_output("hw_v2", 64'(vv[2]), 64'h33);
      check_output("hw_sent", 64'(values_sent), 64'd3);
      check_output("hw_max_delay", 64'(max_delay), 64'd4);

      // PS path, a held read level must not consume the second entry.
      use_hardware = 1'b0;
      write_entry(16'd0, 16'hABCD);
      write_entry(16'd0, 16'h1234);
      n = 0;
      while (!play_if.ps_value_ready && n < 40) begin
         tick();
         n++;
      end
      check_output("ps_ready_up", 64'(play_if.ps_value_ready), 64'd1);
      check_output("ps_value_first", 64'(play_if.ps_value), 64'hABCD);
      tick();
      tick();
      tick();
      check_output("ps_ready_holds", 64'(play_if.ps_value_ready), 64'd1);
      play_if.ps_value_read = 1'b1;
      tick();
      check_output("ps_ready_drop", 64'(play_if.ps_value_ready), 64'd0);
      check_output("ps_sent_4", 64'(values_sent), 64'd4);
      for (int i = 0; i < 12; i++) tick();
      check_output("ps_level_no_pop", 64'(play_if.ps_value_ready), 64'd1);
      check_output("ps_value_second", 64'(play_if.ps_value), 64'h1234);
      check_output("ps_sent_still_4", 64'(values_sent), 64'd4);
      play_if.ps_value_read = 1'b0;
      tick();
      play_if.ps_value_read = 1'b1;
      tick();
      play_if.ps_value_read = 1'b0;
      check_output("ps_ready_drop2", 64'(play_if.ps_value_ready), 64'd0);
      check_output("ps_sent_5", 64'(values_sent), 64'd5);
      check_output("ps_value_holds", 64'(play_if.ps_value), 64'h1234);

      // Fill to capacity, drop a ninth write, then accept a write against a pop.
      use_hardware = 1'b1;
      play_if.hist_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) write_entry(16'd0, 16'(16'h0100 + i));
      check_output("full_occupancy", 64'(occupancy), 64'd8);
      check_output("full_overflow_0", 64'(overflow), 64'd0);
      write_entry(16'd0, 16'h01FF);
      check_output("ovf_flag", 64'(overflow), 64'd1);
      check_output("ovf_received", 64'(values_received), 64'd8);
      check_output("ovf_occupancy", 64'(occupancy), 64'd8);
      pulse_start();
      tick();
      tick();
      check_output("full_present", 64'(play_if.hist_valid), 64'd1);
      check_output("full_first_value", 64'(play_if.hist_value), 64'h0100);
      ethernet_value = {16'd0, 16'h0155};
      ethernet_write = 1'b1;
      tick();
      ethernet_write = 1'b0;
      play_if.hist_ready = 1'b1;
      tick();
      play_if.hist_ready = 1'b0;
      check_output("popwr_received", 64'(values_received), 64'd9);
      check_output("popwr_occupancy", 64'(occupancy), 64'd8);
      check_output("popwr_sent", 64'(values_sent), 64'd1);
      check_output("popwr_overflow_sticky", 64'(overflow), 64'd1);

      // Empty-buffer stalls repeat every STALL_DELAY+1 cycles.
      play_if.hist_ready = 1'b1;
      do_reset();
      pulse_start();
      tick();
      check_output("stall_first", 64'(underflow_stalls), 64'd1);
      for (int i = 0; i < 10; i++) tick();
      check_output("stall_before_second", 64'(underflow_stalls), 64'd1);
      tick();
      check_output("stall_second", 64'(underflow_stalls), 64'd2);
      write_entry(16'd0, 16'h0077);
      n = 0;
      while (!play_if.hist_valid && n < 40) begin
         tick();
         n++;
      end
      check_output("stall_delivered", 64'(play_if.hist_valid), 64'd1);
      check_output("stall_value", 64'(play_if.hist_value), 64'h0077);

      // Refill interrupt, clear holdoff, and clear winning over set.
      play_if.hist_ready = 1'b0;
      do_reset();
      load_floor = 4'd2;
      for (int i = 0; i < 4; i++) write_entry(16'd0, 16'(16'h0200 + i));
      check_output("irq_idle_low", 64'(request_values), 64'd0);
      pulse_start();
      check_output("irq_start_high", 64'(request_values), 64'd1);
      clear_request = 1'b1;
      tick();
      clear_request = 1'b0;
      check_output("irq_cleared", 64'(request_values), 64'd0);
      for (int i = 0; i < 60; i++) tick();
      check_output("irq_above_floor", 64'(request_values), 64'd0);
      play_if.hist_ready = 1'b1;
      n = 0;
      while (occupancy != 4'd2 && n < 40) begin
         tick();
         n++;
      end
      play_if.hist_ready = 1'b0;
      tick();
      check_output("irq_floor_occ", 64'(occupancy), 64'd2);
      check_output("irq_floor_high", 64'(request_values), 64'd1);
      clear_request = 1'b1;
      tick();
      clear_request = 1'b0;
      check_output("irq_clear_beats_set", 64'(request_values), 64'd0);
      n = 0;
      while (!request_values && n < 100) begin
         tick();
         n++;
      end
      check_output("irq_holdoff_len", 64'(n), 64'd51);

      // Asynchronous reset while an entry is waiting out its delay.
      do_reset();
      write_entry(16'd10, 16'h0055);
      pulse_start();
      tick();
      tick();
      check_output("wait_no_valid", 64'(play_if.hist_valid), 64'd0);
      check_output("wait_max_delay", 64'(max_delay), 64'd10);
      reset = 1'b0;
      #1;
      check_output("rst_max_delay", 64'(max_delay), 64'd0);
      check_output("rst_occupancy", 64'(occupancy), 64'd0);
      check_output("rst_received", 64'(values_received), 64'd0);
      check_output("rst_request", 64'(request_values), 64'd0);
      check_output("rst_underflow", 64'(underflow_stalls), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      play_if.hist_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check_output("post_rst_idle_valid", 64'(play_if.hist_valid), 64'd0);
      check_output("post_rst_idle_sent", 64'(values_sent), 64'd0);
      check_output("post_rst_idle_stalls", 64'(underflow_stalls), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/radiation_playback_engine.md
Name: radiation_playback_engine

Overview:
Parametrised successor to the single-buffer radiation receiver. Synthetic radiation entries arrive from the PS over AXI-written registers and are stored in a circular on-chip buffer. Each entry packs a value and an inter-arrival delay. A playback FSM replays the entries with cycle-accurate spacing, either to the PS (register/ack) or to the hardware histogram (valid/ready), selectable per sample. A refill interrupt, overflow flag and underflow statistics are also produced.

Parameters:
ADDR_WIDTH, 14, buffer depth = 2^ADDR_WIDTH entries
VALUE_WIDTH, 16, radiation value width (entry low bits)
DELAY_WIDTH, 16, delay field width (entry high bits)
STALL_DELAY, 50000, cycles waited before re-checking an empty buffer
IRQ_HOLDOFF, 50, cycles request_values is held low after clear_request

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low
start  in  1  pulse; begin playback
ethernet_value  in  DELAY_WIDTH+VALUE_WIDTH  entry {delay,value}
ethernet_write  in  1  level write strobe from AXI; rising edge stores entry
load_floor  in  ADDR_WIDTH+1  refill threshold (occupancy)
clear_request  in  1  pulse; acknowledge interrupt
use_hardware  in  1  1 = histogram path, 0 = PS path
ps_value  out  VALUE_WIDTH  value presented to PS
ps_value_ready  out  1  PS value valid
ps_value_read  in  1  level; rising edge = PS consumed value
hist_value  out  VALUE_WIDTH  value to histogram
hist_valid  out  1  histogram valid
hist_ready  in  1  histogram ready
request_values  out  1  interrupt: buffer needs refill
occupancy  out  ADDR_WIDTH+1  entries stored
values_received  out  32  entries accepted
values_sent  out  32  entries delivered
overflow  out  1  sticky; a write was dropped
underflow_stalls  out  16  saturating count of empty-buffer stalls
max_delay  out  DELAY_WIDTH  largest delay loaded

Behaviour:
- Reset (async, reset=0): all outputs 0, pointers 0, FSM IDLE, holdoff 0.
- Write: a rising edge of ethernet_write (registered edge detect) writes ethernet_value at wr_ptr in the next cycle. wr_ptr then increments and values_received increments.
- The write is accepted if occupancy < 2^ADDR_WIDTH, or if a pop occurs in the same cycle. Otherwise it is dropped, overflow is set and the counters are unchanged.
- Occupancy = wr_ptr - rd_ptr, ADDR_WIDTH+1 bits, with natural wrap.
- Memory: synchronous read, 1-cycle latency.
- FSM states: IDLE, FETCH, LOAD, WAIT, PRESENT, STALL.
  - IDLE -> FETCH on start. A start pulse in any other state is ignored.
  - FETCH: if occupancy 0, go to STALL, load stall counter = STALL_DELAY-1, and increment underflow_stalls (saturating at 0xFFFF). Otherwise issue the read at rd_ptr and go to LOAD.
  - LOAD: latch value and delay counter; update max_delay if the new delay is larger; latch mode = use_hardware. If delay = 0 go to PRESENT, else go to WAIT.
  - WAIT: decrement the delay counter; go to PRESENT in the cycle it reaches 0. A delay of N gives N WAIT cycles.
  - PRESENT, hardware mode: hist_valid=1 with hist_value stable until hist_ready is sampled high.
  - PRESENT, PS mode: ps_value_ready=1 with ps_value stable until a rising edge of ps_value_read. ps_value holds after ready drops.
  - On handshake: pop (rd_ptr+1), values_sent+1, valid/ready deasserted the next cycle, go to FETCH.
  - STALL: count down to 0, then go to FETCH.
- Sample latency when data is present: FETCH -> LOAD -> WAIT(delay) -> PRESENT, i.e. valid delay+2 cycles after FETCH.
- request_values:
  - set on a start pulse, or when FSM != IDLE and occupancy <= load_floor and holdoff = 0;
  - clear_request clears it and loads holdoff = IRQ_HOLDOFF; holdoff decrements to 0 and forces request low while nonzero;
  - clear_request beats set in the same cycle.
- Mid-operation reset: everything returns to reset values; buffer contents are not guaranteed.
- Counters wrap at 2^32. max_delay clears only on reset.

Test Plan:
- Write 3 entries {delay=4,val=0x11},{0,0x22},{2,0x33}, use_hardware=1, hist_ready=1, start -> hist_valid pulses carry 0x11,0x22,0x33. Spacing matches delay+2 rules. values_sent=3, max_delay=4.
- PS mode: one entry {0,0xABCD} -> ps_value_ready holds until a ps_value_read rising edge. A level held high does not consume a second entry.
- Fill to 2^ADDR_WIDTH (use ADDR_WIDTH=3, so 8 entries), write a 9th -> dropped, overflow=1, values_received=8. A write coincident with a pop when full -> accepted.
- Start with empty buffer, STALL_DELAY=10 -> underflow_stalls increments every 11 cycles. Write an entry -> it is delivered after the current stall expires.
- load_floor=2, occupancy falls to 2 -> request_values=1. A clear_request pulse -> low for IRQ_HOLDOFF=50 cycles, then reasserts while occupancy<=2. Clear and set in the same cycle -> stays 0.
- Assert reset during WAIT with hist_valid pending -> all outputs 0 immediately. After release the FSM stays IDLE until start.
